// File: rtl/lsu_rv32.sv
// RV32I load/store unit: decodes a pipeline memory command, formats it for a
// word-wide data cache, and returns aligned, extended load data on a oDone pulse.
module lsu_rv32 #(
  parameter int MAX_STALL = 255
) (
  input  logic        iCLK,
  input  logic        iRSTn,
  input  logic        iValid,
  output logic        oReady,
  input  logic        iIsStore,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWData,
  output logic        oDone,
  output logic [31:0] oRData,
  output logic        oMisalign,
  output logic        oErr,
  output logic        oDReq,
  output logic        oDWe,
  output logic [31:0] oDAddr,
  output logic [31:0] oDWData,
  output logic [3:0]  oDBe,
  input  logic        iDStall,
  input  logic [31:0] iDRData
);

  localparam int CW = $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RDATA = 2'd2
  } state_t;

  state_t         state, nextState;
  logic [31:0]    addrQ;
  logic [2:0]     funct3Q;
  logic           isStoreQ;
  logic [31:0]    wdataQ;
  logic [3:0]     beQ;
  logic [CW-1:0]  stallCnt;

  logic           cmdLegal, cmdMisalign, cmdFault, accept, stallHit;
  logic [31:0]    fmtData;
  logic [3:0]     fmtBe;
  logic [31:0]    shifted, loadExt;

  assign oReady   = (state == IDLE);
  assign accept   = iValid && oReady;
  assign cmdFault = !cmdLegal || cmdMisalign;
  assign stallHit = iDStall && (stallCnt == CW'(MAX_STALL - 1));

  // Command decode: legality, alignment and store-lane formatting.
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cmdLegal    = 1'b0;
    cmdMisalign = 1'b0;
    fmtData     = '0;
    fmtBe       = 4'b1111;
    if (iIsStore) begin
      case (iFunct3)
        3'b000, 3'b001, 3'b010: cmdLegal = 1'b1;
        default:                cmdLegal = 1'b0;
      endcase
    end else begin
      case (iFunct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: cmdLegal = 1'b1;
        default:                                cmdLegal = 1'b0;
      endcase
    end
    case (iFunct3[1:0])
      2'b01:   cmdMisalign = iAddr[0];
      2'b10:   cmdMisalign = |iAddr[1:0];
      default: cmdMisalign = 1'b0;
    endcase
    if (iIsStore) begin
      case (iFunct3[1:0])
        2'b00: begin
          fmtData = {4{iWData[7:0]}};
          fmtBe   = 4'b0001 << iAddr[1:0];
        end
        2'b01: begin
          fmtData = {2{iWData[15:0]}};
          fmtBe   = 4'b0011 << iAddr[1:0];
        end
        default: begin
          fmtData = iWData;
          fmtBe   = 4'b1111;
        end
      endcase
    end
  end

  // Load alignment and extension from the latched address and funct3.
  assign shifted = iDRData >> {addrQ[1:0], 3'b000};

  always_comb begin
    loadExt = shifted;
    case (funct3Q)
      3'b000:  loadExt = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  loadExt = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  loadExt = {24'd0, shifted[7:0]};
      3'b101:  loadExt = {16'd0, shifted[15:0]};
      default: loadExt = shifted;
    endcase
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept && !cmdFault) nextState = REQ;
      REQ: begin
        if (!iDStall)     nextState = isStoreQ ? IDLE : RDATA;
        else if (stallHit) nextState = IDLE;
      end
      RDATA:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state     <= IDLE;
      addrQ     <= '0;
      funct3Q   <= '0;
      isStoreQ  <= 1'b0;
      wdataQ    <= '0;
      beQ       <= '0;
      stallCnt  <= '0;
      oDone     <= 1'b0;
      oErr      <= 1'b0;
      oMisalign <= 1'b0;
      oRData    <= '0;
    end else begin
      state     <= nextState;
      oDone     <= 1'b0;
      oErr      <= 1'b0;
      oMisalign <= 1'b0;
      if (accept) begin
        addrQ    <= iAddr;
        funct3Q  <= iFunct3;
        isStoreQ <= iIsStore;
        wdataQ   <= fmtData;
        beQ      <= fmtBe;
        stallCnt <= '0;
      end else if (state == REQ && iDStall) begin
        stallCnt <= stallCnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept && cmdFault) begin
            oDone     <= 1'b1;
            oErr      <= !cmdLegal;
            oMisalign <= cmdLegal && cmdMisalign;
          end
        end
        REQ: begin
          if (!iDStall && isStoreQ) begin
            oDone <= 1'b1;
          end else if (stallHit) begin
            oDone <= 1'b1;
            oErr  <= 1'b1;
          end
        end
        RDATA: begin
          oDone  <= 1'b1;
          oRData <= loadExt;
        end
        default: ;
      endcase
    end
  end

  // Cache-side outputs come straight from state and latched command fields,
  // so an asynchronous reset drops oDReq immediately.
  assign oDReq   = (state == REQ);
  assign oDWe    = oDReq && isStoreQ;
  assign oDAddr  = {addrQ[31:2], 2'b00};
  assign oDWData = wdataQ;
  assign oDBe    = beQ;

endmodule

// File: tb/tb_lsu_rv32.sv
// Directed self-checking bench for lsu_rv32: latency, formatting, faults,
// stall timeout, back-to-back commands and mid-transaction reset.
module tb_lsu_rv32;

  logic        iCLK = 1'b0;
  logic        iRSTn;
  logic        iValid;
  logic        oReady;
  logic        iIsStore;
  logic [2:0]  iFunct3;
  logic [31:0] iAddr;
  logic [31:0] iWData;
  logic        oDone;
  logic [31:0] oRData;
  logic        oMisalign;
  logic        oErr;
  logic        oDReq;
  logic        oDWe;
  logic [31:0] oDAddr;
  logic [31:0] oDWData;
  logic [3:0]  oDBe;
  logic        iDStall;
  logic [31:0] iDRData;

  int checks   = 0;
  int failures = 0;

  lsu_rv32 #(.MAX_STALL(4)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iValid(iValid), .oReady(oReady),
    .iIsStore(iIsStore), .iFunct3(iFunct3), .iAddr(iAddr), .iWData(iWData),
    .oDone(oDone), .oRData(oRData), .oMisalign(oMisalign), .oErr(oErr),
    .oDReq(oDReq), .oDWe(oDWe), .oDAddr(oDAddr), .oDWData(oDWData),
    .oDBe(oDBe), .iDStall(iDStall), .iDRData(iDRData)
  );

  always #5 iCLK = ~iCLK;

  // Presents a command before accept edge 0; returns at the negedge of cycle 1.
  task automatic issue(input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge iCLK);
    iValid = 1'b1; iIsStore = st; iFunct3 = f3; iAddr = a; iWData = wd;
    @(negedge iCLK);
    iValid = 1'b0;
  endtask

  task automatic test_reset;
    iRSTn = 1'b0; iValid = 1'b0; iIsStore = 1'b0; iFunct3 = 3'b000;
    iAddr = '0; iWData = '0; iDStall = 1'b0; iDRData = '0;
    repeat (3) @(negedge iCLK);
    checks++;
    if (oDReq !== 1'b0 || oDWe !== 1'b0 || oDone !== 1'b0 || oErr !== 1'b0 || oMisalign !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got req=%b we=%b done=%b err=%b mis=%b want all 0",
               oDReq, oDWe, oDone, oErr, oMisalign);
    end
    checks++;
    if (oRData !== 32'h0 || oDAddr !== 32'h0 || oDWData !== 32'h0 || oDBe !== 4'h0) begin
      failures++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h be=%h want all 0",
               oRData, oDAddr, oDWData, oDBe);
    end
    iRSTn = 1'b1;
    @(negedge iCLK);
    checks++;
    if (oReady !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b want 1", oReady);
    end
  endtask

  task automatic test_lw;
    iDRData = 32'hDEADBEEF;
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    checks++;
    if (oDReq !== 1'b1 || oDAddr !== 32'h100 || oDBe !== 4'hF || oDWe !== 1'b0 || oDone !== 1'b0) begin
      failures++;
      $display("FAIL lw_req: got req=%b addr=%h be=%h we=%b done=%b want 1 00000100 f 0 0",
               oDReq, oDAddr, oDBe, oDWe, oDone);
    end
    @(negedge iCLK);
    checks++;
    if (oDReq !== 1'b0 || oDone !== 1'b0) begin
      failures++;
      $display("FAIL lw_cycle2: got req=%b done=%b want 0 0", oDReq, oDone);
    end
    @(negedge iCLK);
    checks++;
    if (oDone !== 1'b1 || oRData !== 32'hDEADBEEF || oErr !== 1'b0 || oMisalign !== 1'b0) begin
      failures++;
      $display("FAIL lw_done: got done=%b rdata=%h err=%b mis=%b want 1 deadbeef 0 0",
               oDone, oRData, oErr, oMisalign);
    end
    iDRData = 32'h11111111;
    @(negedge iCLK);
    checks++;
    if (oDone !== 1'b0 || oRData !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL lw_hold: got done=%b rdata=%h want 0 deadbeef", oDone, oRData);
    end
  endtask

  task automatic test_load_ext;
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] as  [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    iDRData = 32'h80FFFFFF;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, f3s[i], as[i], 32'h0);
      checks++;
      if (oDBe !== 4'hF || oDAddr !== 32'h100) begin
        failures++;
        $display("FAIL ext_req[%0d]: got be=%h addr=%h want f 00000100", i, oDBe, oDAddr);
      end
      repeat (2) @(negedge iCLK);
      checks++;
      if (oDone !== 1'b1 || oRData !== exp[i]) begin
        failures++;
        $display("FAIL ext_data[%0d]: got done=%b rdata=%h want 1 %h", i, oDone, oRData, exp[i]);
      end
    end
  endtask

  task automatic test_sh_stall;
    iDStall = 1'b1;
    issue(1'b1, 3'b001, 32'h22, 32'h0000ABCD);
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (oDReq !== 1'b1 || oDWe !== 1'b1 || oDWData !== 32'hABCDABCD || oDBe !== 4'b1100 ||
          oDAddr !== 32'h20 || oDone !== 1'b0) begin
        failures++;
        $display("FAIL sh_stall_c%0d: got req=%b we=%b wdata=%h be=%b addr=%h done=%b want 1 1 abcdabcd 1100 00000020 0",
                 c, oDReq, oDWe, oDWData, oDBe, oDAddr, oDone);
      end
      @(negedge iCLK);
    end
    iDStall = 1'b0;
    checks++;
    if (oDReq !== 1'b1 || oDWe !== 1'b1 || oDone !== 1'b0) begin
      failures++;
      $display("FAIL sh_c4: got req=%b we=%b done=%b want 1 1 0", oDReq, oDWe, oDone);
    end
    @(negedge iCLK);
    checks++;
    if (oDone !== 1'b1 || oDReq !== 1'b0 || oErr !== 1'b0 || oRData !== 32'h000080FF) begin
      failures++;
      $display("FAIL sh_done: got done=%b req=%b err=%b rdata=%h want 1 0 0 000080ff",
               oDone, oDReq, oErr, oRData);
    end
  endtask

  task automatic test_faults;
    logic        sts [3] = '{1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s [3] = '{3'b010, 3'b011, 3'b101};
    logic [31:0] as  [3] = '{32'h101, 32'h100, 32'h101};
    logic        eEr [3] = '{1'b0, 1'b1, 1'b1};
    logic        eMs [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      issue(sts[i], f3s[i], as[i], 32'h0);
      checks++;
      if (oDone !== 1'b1 || oErr !== eEr[i] || oMisalign !== eMs[i] || oDReq !== 1'b0) begin
        failures++;
        $display("FAIL fault[%0d]: got done=%b err=%b mis=%b req=%b want 1 %b %b 0",
                 i, oDone, oErr, oMisalign, oDReq, eEr[i], eMs[i]);
      end
      @(negedge iCLK);
      checks++;
      if (oDone !== 1'b0 || oDReq !== 1'b0 || oReady !== 1'b1) begin
        failures++;
        $display("FAIL fault_after[%0d]: got done=%b req=%b ready=%b want 0 0 1",
                 i, oDone, oDReq, oReady);
      end
    end
  endtask

  task automatic test_timeout;
    iDStall = 1'b1;
    issue(1'b1, 3'b010, 32'h40, 32'h12345678);
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (oDReq !== 1'b1 || oDone !== 1'b0 || oDWData !== 32'h12345678) begin
        failures++;
        $display("FAIL timeout_c%0d: got req=%b done=%b wdata=%h want 1 0 12345678",
                 c, oDReq, oDone, oDWData);
      end
      @(negedge iCLK);
    end
    checks++;
    if (oDone !== 1'b1 || oErr !== 1'b1 || oDReq !== 1'b0 || oReady !== 1'b1) begin
      failures++;
      $display("FAIL timeout_done: got done=%b err=%b req=%b ready=%b want 1 1 0 1",
               oDone, oErr, oDReq, oReady);
    end
    iDStall = 1'b0;
    @(negedge iCLK);
  endtask

  task automatic test_back_to_back;
    iDRData = 32'hCAFEF00D;
    issue(1'b1, 3'b000, 32'h41, 32'h0000005A);
    checks++;
    if (oDBe !== 4'b0010 || oDWData !== 32'h5A5A5A5A || oDWe !== 1'b1) begin
      failures++;
      $display("FAIL sb_fmt: got be=%b wdata=%h we=%b want 0010 5a5a5a5a 1", oDBe, oDWData, oDWe);
    end
    @(negedge iCLK);
    checks++;
    if (oDone !== 1'b1 || oReady !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done: got done=%b ready=%b want 1 1", oDone, oReady);
    end
    iValid = 1'b1; iIsStore = 1'b0; iFunct3 = 3'b010; iAddr = 32'h200;
    @(negedge iCLK);
    iValid = 1'b0;
    checks++;
    if (oDReq !== 1'b1 || oDAddr !== 32'h200 || oDWe !== 1'b0 || oDBe !== 4'hF) begin
      failures++;
      $display("FAIL b2b_req: got req=%b addr=%h we=%b be=%h want 1 00000200 0 f",
               oDReq, oDAddr, oDWe, oDBe);
    end
    repeat (2) @(negedge iCLK);
    checks++;
    if (oDone !== 1'b1 || oRData !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL b2b_load: got done=%b rdata=%h want 1 cafef00d", oDone, oRData);
    end
  endtask

  task automatic test_reset_mid;
    int doneSeen = 0;
    iDStall = 1'b1;
    issue(1'b1, 3'b010, 32'h80, 32'h55AA55AA);
    #2 iRSTn = 1'b0;
    #1;
    checks++;
    if (oDReq !== 1'b0 || oDWe !== 1'b0 || oDAddr !== 32'h0 || oRData !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid: got req=%b we=%b addr=%h rdata=%h want 0 0 0 0",
               oDReq, oDWe, oDAddr, oRData);
    end
    iDStall = 1'b0;
    @(negedge iCLK);
    iRSTn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge iCLK);
      if (oDone === 1'b1 || oDReq === 1'b1) doneSeen++;
    end
    checks++;
    if (doneSeen != 0 || oReady !== 1'b1) begin
      failures++;
      $display("FAIL rst_release: got activity=%0d ready=%b want 0 1", doneSeen, oReady);
    end
  endtask

  initial begin
    test_reset;
    test_lw;
    test_load_ext;
    test_sh_stall;
    test_faults;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
